// File: rtl/mem_config_mc.sv
// Register-mapped configuration block for a multi-channel transfer engine.
// Holds per-channel base/size registers, a start/busy/done/IE control word, and the interrupt.
module mem_config_mc #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CH_BITS    = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         cs,
  input  logic                         we,
  input  logic                         oe,
  input  logic [CH_BITS+1:0]           addr,
  input  logic [DATA_WIDTH-1:0]        datain,
  output logic [DATA_WIDTH-1:0]        dataout,
  output logic                         dataout_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] oBase_Rd_add,
  output logic [NUM_CH*DATA_WIDTH-1:0] oBase_Wr_add,
  output logic [NUM_CH*DATA_WIDTH-1:0] oSize,
  output logic [NUM_CH-1:0]            oStart,
  input  logic [NUM_CH-1:0]            iDone,
  output logic [NUM_CH-1:0]            oBusy,
  output logic                         oIrq
);

  localparam logic [1:0] OFF_RD_BASE = 2'd0;
  localparam logic [1:0] OFF_WR_BASE = 2'd1;
  localparam logic [1:0] OFF_SIZE    = 2'd2;
  localparam logic [1:0] OFF_CTRL    = 2'd3;

  logic [DATA_WIDTH-1:0] rd_base_q [NUM_CH];
  logic [DATA_WIDTH-1:0] wr_base_q [NUM_CH];
  logic [DATA_WIDTH-1:0] size_q    [NUM_CH];
  logic [NUM_CH-1:0]     busy_q, done_q, ie_q, start_q;
  logic [NUM_CH-1:0]     busy_d, done_d, ie_d, start_d;
  logic [NUM_CH-1:0]     ch_hit;
  logic [CH_BITS-1:0]    ch;
  logic [1:0]            off;
  logic                  wr_en, rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  assign ch    = addr[CH_BITS+1:2];
  assign off   = addr[1:0];
  assign wr_en = cs & we;
  assign rd_en = cs & ~we & oe;

  // One-hot channel decode; an out-of-range channel matches nothing.
  always_comb begin
    ch_hit = '0;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      ch_hit[n] = (ch == CH_BITS'(n));
    end
  end

  // Control-word next state: engine completion is applied last so it wins over W1C and START.
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    ie_d    = ie_q;
    start_d = '0;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      if (wr_en && ch_hit[n] && off == OFF_CTRL) begin
        ie_d[n] = datain[3];
        if (datain[2]) done_d[n] = 1'b0;
        if (datain[0] && !busy_q[n]) begin
          if (size_q[n] != '0) begin
            start_d[n] = 1'b1;
            busy_d[n]  = 1'b1;
            done_d[n]  = 1'b0;
          end else begin
            done_d[n]  = 1'b1;
          end
        end
      end
      if (busy_q[n] && iDone[n]) begin
        busy_d[n] = 1'b0;
        done_d[n] = 1'b1;
      end
    end
  end

  // Read mux; unmatched channels read as zero.
  always_comb begin
    rd_data = '0;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      if (ch_hit[n]) begin
        case (off)
          OFF_RD_BASE: rd_data = rd_base_q[n];
          OFF_WR_BASE: rd_data = wr_base_q[n];
          OFF_SIZE:    rd_data = size_q[n];
          default:     rd_data = DATA_WIDTH'({ie_q[n], done_q[n], busy_q[n], 1'b0});
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int n = 0; n < int'(NUM_CH); n++) begin
        rd_base_q[n] <= '0;
        wr_base_q[n] <= '0;
        size_q[n]    <= '0;
      end
      busy_q        <= '0;
      done_q        <= '0;
      ie_q          <= '0;
      start_q       <= '0;
      dataout       <= '0;
      dataout_valid <= 1'b0;
    end else begin
      // Configuration registers are frozen while their channel is busy.
      for (int n = 0; n < int'(NUM_CH); n++) begin
        if (wr_en && ch_hit[n] && !busy_q[n]) begin
          case (off)
            OFF_RD_BASE: rd_base_q[n] <= datain;
            OFF_WR_BASE: wr_base_q[n] <= datain;
            OFF_SIZE:    size_q[n]    <= datain;
            default:     ;
          endcase
        end
      end
      busy_q        <= busy_d;
      done_q        <= done_d;
      ie_q          <= ie_d;
      start_q       <= start_d;
      dataout_valid <= rd_en;
      if (rd_en) dataout <= rd_data;
    end
  end

  for (genvar n = 0; n < int'(NUM_CH); n++) begin : g_pack
    assign oBase_Rd_add[n*DATA_WIDTH +: DATA_WIDTH] = rd_base_q[n];
    assign oBase_Wr_add[n*DATA_WIDTH +: DATA_WIDTH] = wr_base_q[n];
    assign oSize[n*DATA_WIDTH +: DATA_WIDTH]        = size_q[n];
  end

  assign oStart = start_q;
  assign oBusy  = busy_q;
  assign oIrq   = |(done_q & ie_q);

endmodule

// File: tb/tb_mem_config_mc.sv
// Directed bench for mem_config_mc: read responses are checked by a scoreboard monitor,
// control outputs are checked inline right after the edge that updates them.
module tb_mem_config_mc;

  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 2;
  localparam int unsigned CHB = 2;

  logic            clock = 1'b0;
  logic            reset_n, cs, we, oe;
  logic [CHB+1:0]  addr;
  logic [DW-1:0]   datain, dataout;
  logic            dataout_valid;
  logic [NCH*DW-1:0] oBase_Rd_add, oBase_Wr_add, oSize;
  logic [NCH-1:0]  oStart, iDone, oBusy;
  logic            oIrq;

  int vectors = 0;
  int errors  = 0;
  logic [DW-1:0] exp_q[$];

  mem_config_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CH_BITS(CHB)) dut (
    .clock(clock), .reset_n(reset_n), .cs(cs), .we(we), .oe(oe), .addr(addr),
    .datain(datain), .dataout(dataout), .dataout_valid(dataout_valid),
    .oBase_Rd_add(oBase_Rd_add), .oBase_Wr_add(oBase_Wr_add), .oSize(oSize),
    .oStart(oStart), .iDone(iDone), .oBusy(oBusy), .oIrq(oIrq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every dataout_valid pulse must match the oldest expected read.
  always @(negedge clock) begin
    if (dataout_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got dataout 0x%0h with no read pending", dataout);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (dataout !== e) begin
          errors++;
          $display("FAIL read_data: got 0x%0h expected 0x%0h", dataout, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    cs = 1'b1; we = 1'b1; oe = 1'b0; addr = (CHB+2)'(a); datain = d;
    step();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] e);
    cs = 1'b1; we = 1'b0; oe = 1'b1; addr = (CHB+2)'(a);
    exp_q.push_back(e);
    step();
    cs = 1'b0; oe = 1'b0;
  endtask

  task automatic pulse_done(input logic [NCH-1:0] d);
    iDone = d;
    step();
    iDone = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cs = 1'b0; we = 1'b0; oe = 1'b0; addr = '0; datain = '0; iDone = '0;
    step(); step();
    reset_n = 1'b1;
    chk("rst_dataout", 64'(dataout), 64'h0);
    chk("rst_valid", 64'(dataout_valid), 64'h0);
    chk("rst_start", 64'(oStart), 64'h0);
    chk("rst_busy", 64'(oBusy), 64'h0);
    chk("rst_irq", 64'(oIrq), 64'h0);

    // Every offset of every channel reads zero after reset, including unmapped channels.
    for (int a = 0; a < 16; a++) rd(a, 32'h0);
    chk("rst_irq_after_reads", 64'(oIrq), 64'h0);

    // Channel 1 start, then a SIZE write while busy must be ignored.
    wr(6, 32'h100);
    wr(7, 32'h9);
    chk("ch1_start_pulse", 64'(oStart), 64'h2);
    chk("ch1_busy", 64'(oBusy), 64'h2);
    step();
    chk("ch1_start_one_cycle", 64'(oStart), 64'h0);
    wr(6, 32'h55);
    chk("ch1_size_frozen", oSize, {32'h100, 32'h0});
    rd(7, 32'hA);

    // Completion sets DONE and raises the interrupt; W1C (with IE=0) clears both.
    pulse_done(2'b10);
    chk("ch1_busy_cleared", 64'(oBusy), 64'h0);
    chk("ch1_irq_set", 64'(oIrq), 64'h1);
    rd(7, 32'hC);
    wr(7, 32'h4);
    chk("ch1_irq_cleared", 64'(oIrq), 64'h0);
    rd(7, 32'h0);

    // Zero-size start on channel 0: no pulse, DONE set immediately.
    wr(3, 32'h1);
    chk("ch0_zero_size_no_start", 64'(oStart), 64'h0);
    chk("ch0_zero_size_not_busy", 64'(oBusy), 64'h0);
    rd(3, 32'h4);

    // Real start clears DONE; completion coincident with W1C leaves DONE set.
    wr(2, 32'h10);
    wr(3, 32'h1);
    chk("ch0_start_pulse", 64'(oStart), 64'h1);
    rd(3, 32'h2);
    iDone = 2'b01;
    wr(3, 32'h4);
    iDone = '0;
    chk("ch0_done_vs_w1c_busy", 64'(oBusy), 64'h0);
    rd(3, 32'h4);

    // iDone while idle is ignored.
    wr(3, 32'h4);
    pulse_done(2'b01);
    rd(3, 32'h0);

    // START coincident with completion on channel 1: START ignored, DONE set.
    wr(7, 32'h1);
    chk("ch1_restart_busy", 64'(oBusy), 64'h2);
    iDone = 2'b10;
    wr(7, 32'h1);
    iDone = '0;
    chk("ch1_start_vs_done_no_pulse", 64'(oStart), 64'h0);
    chk("ch1_start_vs_done_busy", 64'(oBusy), 64'h0);
    rd(7, 32'h4);

    // Reset mid-transfer aborts; a later completion pulse is ignored.
    wr(3, 32'h9);
    chk("ch0_busy_before_reset", 64'(oBusy), 64'h1);
    reset_n = 1'b0;
    iDone = 2'b01;
    step();
    reset_n = 1'b1;
    iDone = '0;
    pulse_done(2'b01);
    chk("abort_busy", 64'(oBusy), 64'h0);
    chk("abort_irq", 64'(oIrq), 64'h0);
    chk("abort_size", oSize, 64'h0);
    rd(3, 32'h0);

    // Write has priority over read; unmapped channels ignore writes and read zero.
    cs = 1'b1; we = 1'b1; oe = 1'b1; addr = 4'd0; datain = 32'hA5A5A5A5;
    step();
    cs = 1'b0; we = 1'b0; oe = 1'b0;
    chk("wr_rd_no_valid", 64'(dataout_valid), 64'h0);
    rd(0, 32'hA5A5A5A5);
    wr(8, 32'h1234);
    wr(12, 32'h5678);
    wr(5, 32'hDEAD0000);
    chk("rd_base_packing", oBase_Rd_add, {32'h0, 32'hA5A5A5A5});
    chk("wr_base_packing", oBase_Wr_add, {32'hDEAD0000, 32'h0});
    rd(12, 32'h0);
    rd(5, 32'hDEAD0000);

    step(); step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_config_mc.md
MEM_CONFIG_MC -- requirements
Module: mem_config_mc

Interface
REQ-001 Parameter DATA_WIDTH, 32, register and data bus width; legal values 16..64.
REQ-002 Parameter NUM_CH, 2, number of independent transfer channels; legal values 1..8.
REQ-003 Parameter CH_BITS, 1, channel-select address bits; SHALL satisfy 2**CH_BITS >= NUM_CH.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 cs  in  1  chip select.
REQ-007 we  in  1  write enable, qualified by cs.
REQ-008 oe  in  1  read enable, qualified by cs and !we.
REQ-009 addr  in  CH_BITS+2  {channel, offset}; offset 0 RD_BASE, 1 WR_BASE, 2 SIZE, 3 CTRL.
REQ-010 datain  in  DATA_WIDTH  write data.
REQ-011 dataout  out  DATA_WIDTH  registered read data.
REQ-012 dataout_valid  out  1  one-cycle pulse marking new dataout.
REQ-013 oBase_Rd_add  out  NUM_CH*DATA_WIDTH  per-channel read base, channel n at bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-014 oBase_Wr_add  out  NUM_CH*DATA_WIDTH  per-channel write base, same packing.
REQ-015 oSize  out  NUM_CH*DATA_WIDTH  per-channel transfer size, same packing.
REQ-016 oStart  out  NUM_CH  per-channel one-cycle start pulse.
REQ-017 iDone  in  NUM_CH  per-channel one-cycle completion pulse from the engine.
REQ-018 oBusy  out  NUM_CH  per-channel busy flag.
REQ-019 oIrq  out  1  level interrupt, OR over channels of (DONE & IE).

Function
REQ-020 CTRL bits: [0] START write-1 action, reads 0; [1] BUSY read-only; [2] DONE sticky, write-1-to-clear; [3] IE read/write; other bits read 0, writes ignored.
REQ-021 Write (cs & we) to RD_BASE/WR_BASE/SIZE of channel n SHALL update that register next edge only when BUSY[n]=0; ignored while busy.
REQ-022 Write to CTRL with START=1, BUSY=0, SIZE!=0: oStart[n]=1 the following cycle for exactly one cycle, BUSY[n]=1 in that same cycle, DONE[n] cleared.
REQ-023 START=1 with SIZE=0 and BUSY=0: no oStart pulse; DONE[n] set next cycle; BUSY stays 0.
REQ-024 START=1 while BUSY=1: ignored, no pulse, no state change except the IE/DONE fields of the same write.
REQ-025 iDone[n]=1 while BUSY[n]=1: BUSY[n] cleared and DONE[n] set next edge; iDone while idle ignored.
REQ-026 Simultaneous iDone[n] and W1C of DONE[n]: set wins, DONE[n]=1.
REQ-027 Simultaneous iDone[n] and START write to channel n: START ignored (BUSY still 1 at decision); BUSY clears, DONE sets.
REQ-028 Read (cs & !we & oe): dataout loads addressed register next edge, dataout_valid=1 for that one cycle; dataout holds value otherwise.
REQ-029 we has priority; cs & we & oe is a write only, no read response.
REQ-030 Channel index >= NUM_CH: writes ignored, reads return 0 with dataout_valid=1.
REQ-031 oBusy[n] equals BUSY[n]; oIrq combinational from registered DONE and IE, no extra latency.
REQ-032 Configuration outputs driven directly from registers, zero latency after write edge.

Reset
REQ-033 reset_n=0 at a rising edge clears all base, size, CTRL fields, dataout, dataout_valid, oStart, BUSY, DONE, IE; oIrq=0.
REQ-034 Reset mid-transfer aborts: BUSY=0, no DONE set, later iDone pulses ignored.
REQ-035 Reset dominates all simultaneous cs, we, oe and iDone activity.

Verification
REQ-036 Reset, then read every offset of every channel -> dataout=0, dataout_valid one-cycle pulse, oIrq=0.
REQ-037 NUM_CH=2: write ch1 SIZE=0x100, CTRL=0x9 -> oStart=2'b10 for one cycle, oBusy[1]=1; write ch1 SIZE=0x55 while busy -> oSize[63:32] stays 0x100.
REQ-038 Pulse iDone[1] -> oBusy[1]=0, CTRL read=0xC, oIrq=1; write CTRL=0x4 -> DONE clears, oIrq=0.
REQ-039 Start ch0 with SIZE=0 -> no oStart, DONE[0]=1 next cycle; iDone[0] coincident with W1C -> DONE remains 1.
REQ-040 Start ch0, assert reset_n=0 one cycle, then iDone[0] -> oBusy=0, DONE=0, oIrq=0.
REQ-041 cs=we=oe=1 to ch0 RD_BASE with 0xA5A5A5A5 -> no dataout_valid; later read returns 0xA5A5A5A5; read addr channel 3 -> 0.
